// File: rtl/fg_pwm_dac.sv
// PWM DAC driver: double-buffered samples are applied at PWM period boundaries.
// Optional sigma-delta output mode is compiled in with FG_PWM_SIGMA_DELTA_EN.
module fg_pwm_dac #(
   parameter int BITWIDTH = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                enable_i,
   input  logic                radix_i,
   input  logic [BITWIDTH-1:0] sample_i,
   input  logic                sampleValid_STRB_i,
`ifdef FG_PWM_SIGMA_DELTA_EN
   input  logic                mode_i,
`endif
   output logic                pwm_o,
   output logic                periodStart_STRB_o,
   output logic                overrun_o
);

   localparam logic [BITWIDTH-1:0] CNT_MAX = '1;

   logic [BITWIDTH-1:0] cnt;
   logic [BITWIDTH-1:0] pending;
   logic [BITWIDTH-1:0] active;
   logic [BITWIDTH-1:0] duty;
   logic                pendValid;
   logic                transfer;
   logic                pwmNext;

   // Two's complement becomes offset-binary by flipping the sign bit.
   assign duty     = radix_i ? sample_i : {~sample_i[BITWIDTH-1], sample_i[BITWIDTH-2:0]};
   assign transfer = (cnt == CNT_MAX);

`ifdef FG_PWM_SIGMA_DELTA_EN
   // The accumulator carry bit is the output itself, so only the low bits are held.
   logic [BITWIDTH-1:0] acc;
   logic [BITWIDTH:0]   accSum;

   assign accSum  = {1'b0, acc} + {1'b0, active};
   assign pwmNext = mode_i ? accSum[BITWIDTH] : (cnt < active);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc <= '0;
      end else if (!enable_i) begin
         acc <= '0;
      end else if (mode_i) begin
         acc <= accSum[BITWIDTH-1:0];
      end
   end
`else
   assign pwmNext = (cnt < active);
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt                <= '0;
         pending            <= '0;
         pendValid          <= 1'b0;
         active             <= '0;
         pwm_o              <= 1'b0;
         periodStart_STRB_o <= 1'b0;
         overrun_o          <= 1'b0;
      end else if (!enable_i) begin
         cnt                <= '0;
         pendValid          <= 1'b0;
         pwm_o              <= 1'b0;
         periodStart_STRB_o <= 1'b0;
         overrun_o          <= 1'b0;
      end else begin
         cnt                <= transfer ? '0 : cnt + 1'b1;
         pwm_o              <= pwmNext;
         periodStart_STRB_o <= (cnt == '0);
         if (transfer && pendValid) begin
            active <= pending;
         end
         // A strobe on the boundary refills the buffer just emptied, so it is not an overrun.
         if (sampleValid_STRB_i) begin
            pending   <= duty;
            pendValid <= 1'b1;
            if (pendValid && !transfer) begin
               overrun_o <= 1'b1;
            end
         end else if (transfer) begin
            pendValid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fg_pwm_dac.sv
// Directed bench for fg_pwm_dac (BITWIDTH = 8); sigma-delta checks run when
// FG_PWM_SIGMA_DELTA_EN is defined.
module tb_fg_pwm_dac;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       enable_i = 1'b1;
   logic       radix_i = 1'b1;
   logic [7:0] sample_i = '0;
   logic       sampleValid_STRB_i = 1'b0;
`ifdef FG_PWM_SIGMA_DELTA_EN
   logic       mode_i = 1'b0;
`endif
   logic       pwm_o;
   logic       periodStart_STRB_o;
   logic       overrun_o;

   int numApplied = 0;
   int numMiscompare = 0;

   typedef struct {
      string      name;
      logic       radix;
      logic [7:0] sample;
      int         expHigh;
   } vec_t;

   vec_t vecs[8];

   fg_pwm_dac #(.BITWIDTH(8)) dut (
      .clk_i              (clk_i),
      .rst_i              (rst_i),
      .enable_i           (enable_i),
      .radix_i            (radix_i),
      .sample_i           (sample_i),
      .sampleValid_STRB_i (sampleValid_STRB_i),
`ifdef FG_PWM_SIGMA_DELTA_EN
      .mode_i             (mode_i),
`endif
      .pwm_o              (pwm_o),
      .periodStart_STRB_o (periodStart_STRB_o),
      .overrun_o          (overrun_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string name, input int actual, input int expected);
      numApplied++;
      if (actual != expected) begin
         numMiscompare++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // One-cycle strobe driven on a falling edge, captured on the following rising edge.
   task automatic applyStimulus(input logic radix, input logic [7:0] sample);
      radix_i            = radix;
      sample_i           = sample;
      sampleValid_STRB_i = 1'b1;
      @(negedge clk_i);
      sampleValid_STRB_i = 1'b0;
   endtask

   task automatic waitPeriodStart();
      bit found = 1'b0;
      for (int i = 0; i < 600 && !found; i++) begin
         @(negedge clk_i);
         if (periodStart_STRB_o) found = 1'b1;
      end
      if (!found) checkOutput("periodStart timeout", 0, 1);
   endtask

   // Counts high cycles over a full period starting with the current sample.
   task automatic countHigh(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         if (i > 0) @(negedge clk_i);
         n += int'(pwm_o);
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int starts;

      vecs[0] = '{"unsigned 64",   1'b1, 8'd64,  64};
      vecs[1] = '{"signed 0x00",   1'b0, 8'h00,  128};
      vecs[2] = '{"signed 0x80",   1'b0, 8'h80,  0};
      vecs[3] = '{"signed 0x7F",   1'b0, 8'h7F,  255};
      vecs[4] = '{"unsigned 0",    1'b1, 8'd0,   0};
      vecs[5] = '{"unsigned 255",  1'b1, 8'd255, 255};
      vecs[6] = '{"signed 0xC0",   1'b0, 8'hC0,  64};
      vecs[7] = '{"unsigned 200",  1'b1, 8'd200, 200};

      repeat (2) @(negedge clk_i);
      checkOutput("reset pwm", pwm_o, 0);
      checkOutput("reset periodStart", periodStart_STRB_o, 0);
      checkOutput("reset overrun", overrun_o, 0);
      rst_i = 1'b0;

      // Mid-period asynchronous reset with a duty of 200 loaded.
      applyStimulus(1'b1, 8'd200);
      waitPeriodStart();
      repeat (50) @(negedge clk_i);
      checkOutput("pre-reset pwm high", pwm_o, 1);
      #2 rst_i = 1'b1;
      #1;
      checkOutput("async reset pwm", pwm_o, 0);
      checkOutput("async reset periodStart", periodStart_STRB_o, 0);
      checkOutput("async reset overrun", overrun_o, 0);
      @(negedge clk_i);
      rst_i = 1'b0;
      n = 0;
      starts = 0;
      for (int i = 0; i < 512; i++) begin
         @(negedge clk_i);
         n += int'(pwm_o);
         starts += int'(periodStart_STRB_o);
      end
      checkOutput("post-reset high count", n, 0);
      checkOutput("post-reset period starts", starts, 2);

      for (int v = 0; v < 8; v++) begin
         waitPeriodStart();
         applyStimulus(vecs[v].radix, vecs[v].sample);
         waitPeriodStart();
         countHigh(256, n);
         checkOutput(vecs[v].name, n, vecs[v].expHigh);
         checkOutput({vecs[v].name, " overrun"}, overrun_o, 0);
      end

      // Two samples in one period: second wins and overrun is flagged.
      waitPeriodStart();
      applyStimulus(1'b1, 8'd10);
      repeat (5) @(negedge clk_i);
      applyStimulus(1'b1, 8'd20);
      checkOutput("overrun set", overrun_o, 1);
      waitPeriodStart();
      countHigh(256, n);
      checkOutput("overrun period high", n, 20);
      checkOutput("overrun sticky", overrun_o, 1);
      enable_i = 1'b0;
      @(negedge clk_i);
      checkOutput("disable overrun", overrun_o, 0);
      checkOutput("disable pwm", pwm_o, 0);
      checkOutput("disable periodStart", periodStart_STRB_o, 0);
      enable_i = 1'b1;
      waitPeriodStart();
      countHigh(256, n);
      checkOutput("re-enable retained duty", n, 20);

      // Strobe exactly when cnt is 255 (cnt register reads 1 at a periodStart sample).
      waitPeriodStart();
      applyStimulus(1'b1, 8'd30);
      repeat (253) @(negedge clk_i);
      applyStimulus(1'b1, 8'd90);
      checkOutput("collision overrun", overrun_o, 0);
      waitPeriodStart();
      countHigh(256, n);
      checkOutput("collision first period", n, 30);
      waitPeriodStart();
      countHigh(256, n);
      checkOutput("collision second period", n, 90);
      checkOutput("collision overrun after", overrun_o, 0);

`ifdef FG_PWM_SIGMA_DELTA_EN
      waitPeriodStart();
      applyStimulus(1'b1, 8'd64);
      waitPeriodStart();
      mode_i = 1'b1;
      repeat (4) @(negedge clk_i);
      countHigh(16, n);
      checkOutput("sigma-delta 64", n, 4);
      applyStimulus(1'b1, 8'd0);
      waitPeriodStart();
      countHigh(256, n);
      checkOutput("sigma-delta 0", n, 0);
      mode_i = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", numApplied, numMiscompare);
      $finish;
   end

endmodule
